mem_stage_resp: RTL and testbench

//  Memory-access pipeline stage for a split-transaction data SRAM (req/addr_ok in EX, data_ok here).

---
 rtl/mem_stage_resp_pkg.sv | 28 ++
 rtl/mem_stage_resp_if.sv | 31 +++
 rtl/mem_stage_resp_ms_load_align.sv | 35 +++
 rtl/mem_stage_resp.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_resp.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_resp_pkg.sv
// Shared definitions for the MEM response stage: load-op bit indices, exception bits, default widths.
package mem_stage_resp_pkg;

    localparam int EXC_W_DEF     = 7;
    localparam int RF_AW_DEF     = 5;
    localparam int MAX_OUTST_DEF = 2;

    // Bit positions inside the one-hot es_ld_op vector {ld_w,ld_h,ld_hu,ld_b,ld_bu}
    localparam int LD_W  = 4;
    localparam int LD_H  = 3;
    localparam int LD_HU = 2;
    localparam int LD_B  = 1;
    localparam int LD_BU = 0;

    // Exception vector bit positions carried EX->MEM->WB
    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_INE  = 4;
    localparam int EXC_ALE  = 5;
    localparam int EXC_ERTN = 6;

    function automatic logic is_load(input logic [4:0] ld_op);
        return |ld_op;
    endfunction

endpackage

// File: rtl/mem_stage_resp_if.sv
// EX->MEM handshake and instruction payload bundle; EX side is master, MEM side is slave.
interface mem_stage_resp_if
    import mem_stage_resp_pkg::*;
#(
    parameter int EXC_W = EXC_W_DEF,
    parameter int RF_AW = RF_AW_DEF
) ();
    logic             es_to_ms_valid;
    logic             ms_allowin;
    logic [31:0]      es_pc;
    logic             es_res_from_mem;
    logic             es_rf_we;
    logic [RF_AW-1:0] es_rf_waddr;
    logic [31:0]      es_alu_result;
    logic [4:0]       es_ld_op;
    logic             es_mem_req;
    logic [EXC_W-1:0] es_except;
    logic             es_req_pending;

    modport master (
        output es_to_ms_valid, es_pc, es_res_from_mem, es_rf_we, es_rf_waddr,
               es_alu_result, es_ld_op, es_mem_req, es_except, es_req_pending,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_res_from_mem, es_rf_we, es_rf_waddr,
               es_alu_result, es_ld_op, es_mem_req, es_except, es_req_pending,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage_resp_ms_load_align.sv
// Combinational load alignment: selects word/half/byte by address low bits and sign/zero extends.
module ms_load_align
    import mem_stage_resp_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        if (ld_op[LD_H]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op[LD_HU]) begin
            result = {16'h0000, half_sel};
        end else if (ld_op[LD_B]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op[LD_BU]) begin
            result = {24'h000000, byte_sel};
        end
    end
endmodule

// File: rtl/mem_stage_resp.sv
// MEM stage for a split-transaction data SRAM: waits for data_ok, buffers it under WB stall, drops stale
// responses after a flush. Optional MS_PERF_CNT_EN adds wait-cycle and dropped-response counters.
module mem_stage_resp
    import mem_stage_resp_pkg::*;
#(
    parameter int EXC_W     = EXC_W_DEF,
    parameter int RF_AW     = RF_AW_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_stage_resp_if.slave      es_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    input  logic                 ms_flush,
    output logic                 ms_to_ws_valid,
    output logic [31:0]          ms_pc,
    output logic                 ms_rf_we,
    output logic [RF_AW-1:0]     ms_rf_waddr,
    output logic [31:0]          ms_rf_wdata,
    output logic [EXC_W-1:0]     ms_except,
    output logic                 ms_ld_busy
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]          perf_wait_cyc,
    output logic [15:0]          perf_drop_cnt
`endif
);
    localparam int DW = $clog2(MAX_OUTST + 1);
    localparam int CW = DW + 1;

    logic             ms_valid_reg;
    logic [31:0]      ms_pc_reg;
    logic             ms_res_from_mem_reg;
    logic             ms_rf_we_reg;
    logic [RF_AW-1:0] ms_rf_waddr_reg;
    logic [31:0]      ms_alu_result_reg;
    logic [4:0]       ms_ld_op_reg;
    logic             ms_mem_req_reg;
    logic [EXC_W-1:0] ms_except_reg;
    logic             got_resp_reg;
    logic             rbuf_valid_reg;
    logic [31:0]      rbuf_reg;
    logic [DW-1:0]    discard_cnt_reg;

    logic          need_resp;
    logic          discard_idle;
    logic          resp_taken;
    logic          resp_drop;
    logic          ms_ready_go;
    logic          ms_allowin_int;
    logic          advance;
    logic          capture;
    logic [CW-1:0] disc_add;
    logic [CW-1:0] disc_sum;
    logic [DW-1:0] discard_cnt_next;
    logic [31:0]   load_data;
    logic [31:0]   load_result;

    assign need_resp      = ms_valid_reg & ms_mem_req_reg & ~got_resp_reg;
    assign discard_idle   = (discard_cnt_reg == '0);
    assign resp_taken     = data_sram_data_ok & discard_idle & need_resp;
    assign resp_drop      = data_sram_data_ok & ~discard_idle;
    assign ms_ready_go    = ~need_resp | (data_sram_data_ok & discard_idle);
    assign ms_allowin_int = ~ms_valid_reg | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~ms_flush;
    assign advance        = ms_to_ws_valid & ws_allowin;
    assign capture        = es_bus.es_to_ms_valid & ms_allowin_int;

    assign es_bus.ms_allowin = ms_allowin_int;

    // A response parked in rbuf takes precedence over whatever the bus carries now
    assign load_data = rbuf_valid_reg ? rbuf_reg : data_sram_rdata;

    ms_load_align u_load_align (
        .ld_op   (ms_ld_op_reg),
        .addr_lo (ms_alu_result_reg[1:0]),
        .rdata   (load_data),
        .result  (load_result)
    );

    // Flush hands off every response still owed (ours if not taken now, plus EX's) to the discard counter
    always_comb begin
        disc_add = CW'(ms_flush & need_resp & ~resp_taken) + CW'(ms_flush & es_bus.es_req_pending);
        disc_sum = CW'(discard_cnt_reg) + disc_add - CW'(resp_drop);
        discard_cnt_next = (disc_sum > CW'(MAX_OUTST)) ? DW'(MAX_OUTST) : disc_sum[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_reg        <= 1'b0;
            ms_pc_reg           <= '0;
            ms_res_from_mem_reg <= 1'b0;
            ms_rf_we_reg        <= 1'b0;
            ms_rf_waddr_reg     <= '0;
            ms_alu_result_reg   <= '0;
            ms_ld_op_reg        <= '0;
            ms_mem_req_reg      <= 1'b0;
            ms_except_reg       <= '0;
            got_resp_reg        <= 1'b0;
            rbuf_valid_reg      <= 1'b0;
            rbuf_reg            <= '0;
            discard_cnt_reg     <= '0;
        end else begin
            if (ms_flush) begin
                ms_valid_reg <= 1'b0;
            end else if (ms_allowin_int) begin
                ms_valid_reg <= es_bus.es_to_ms_valid;
            end
            if (capture) begin
                ms_pc_reg           <= es_bus.es_pc;
                ms_res_from_mem_reg <= es_bus.es_res_from_mem;
                ms_rf_we_reg        <= es_bus.es_rf_we;
                ms_rf_waddr_reg     <= es_bus.es_rf_waddr;
                ms_alu_result_reg   <= es_bus.es_alu_result;
                ms_ld_op_reg        <= es_bus.es_ld_op;
                ms_mem_req_reg      <= es_bus.es_mem_req;
                ms_except_reg       <= es_bus.es_except;
            end
            if (ms_flush || advance) begin
                got_resp_reg   <= 1'b0;
                rbuf_valid_reg <= 1'b0;
            end else if (resp_taken) begin
                got_resp_reg   <= 1'b1;
                rbuf_valid_reg <= ms_res_from_mem_reg;
            end
            if (resp_taken) begin
                rbuf_reg <= data_sram_rdata;
            end
            discard_cnt_reg <= discard_cnt_next;
        end
    end

    assign ms_pc       = ms_pc_reg;
    assign ms_rf_we    = ms_valid_reg & ms_rf_we_reg;
    assign ms_rf_waddr = ms_rf_waddr_reg;
    assign ms_rf_wdata = ms_res_from_mem_reg ? load_result : ms_alu_result_reg;
    assign ms_except   = ms_except_reg;
    assign ms_ld_busy  = ms_valid_reg & ms_res_from_mem_reg & ~ms_ready_go;

`ifdef MS_PERF_CNT_EN
    logic [31:0] perf_wait_cyc_reg;
    logic [15:0] perf_drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_wait_cyc_reg <= '0;
            perf_drop_cnt_reg <= '0;
        end else begin
            if (need_resp) begin
                perf_wait_cyc_reg <= perf_wait_cyc_reg + 32'd1;
            end
            if (resp_drop) begin
                perf_drop_cnt_reg <= perf_drop_cnt_reg + 16'd1;
            end
        end
    end

    assign perf_wait_cyc = perf_wait_cyc_reg;
    assign perf_drop_cnt = perf_drop_cnt_reg;
`endif

    a_discard_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(disc_sum > CW'(MAX_OUTST)));

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(data_sram_data_ok && discard_idle && !need_resp));

endmodule

// File: tb/tb_mem_stage_resp.sv
// Directed table-driven bench for mem_stage_resp; one vector per clock, outputs checked mid-cycle.
module tb_mem_stage_resp;
    import mem_stage_resp_pkg::*;

    localparam logic [4:0] OPW  = 5'b10000;
    localparam logic [4:0] OPH  = 5'b01000;
    localparam logic [4:0] OPHU = 5'b00100;
    localparam logic [4:0] OPB  = 5'b00010;
    localparam logic [4:0] OPBU = 5'b00001;

    typedef struct {
        string       nm;
        logic        v;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  op;
        logic        mreq;
        logic        dok;
        logic [31:0] rd;
        logic        wsa;
        logic        fl;
        logic        pend;
        logic        x_allow;
        logic        x_tows;
        logic        x_we;
        logic        x_busy;
        logic [31:0] x_pc;
        logic        cw;
        logic [31:0] x_wd;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_flush;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic [6:0]  ms_except;
    logic        ms_ld_busy;
`ifdef MS_PERF_CNT_EN
    logic [31:0] perf_wait_cyc;
    logic [15:0] perf_drop_cnt;
`endif

    logic [6:0] exc_in;
    int n_vec;
    int n_miss;
    vec_t tbl[$];

    mem_stage_resp_if #(.EXC_W(7), .RF_AW(5)) es_bus ();

    mem_stage_resp #(.EXC_W(7), .RF_AW(5), .MAX_OUTST(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_bus            (es_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_flush          (ms_flush),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_except         (ms_except),
        .ms_ld_busy        (ms_ld_busy)
`ifdef MS_PERF_CNT_EN
        ,
        .perf_wait_cyc     (perf_wait_cyc),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic v, input logic [31:0] pc, input logic [31:0] alu,
                                input logic [4:0] op, input logic mreq, input logic dok, input logic [31:0] rd,
                                input logic wsa, input logic fl, input logic pend,
                                input logic xa, input logic xt, input logic xw, input logic xb,
                                input logic [31:0] xpc, input logic cw, input logic [31:0] xwd);
        vec_t t;
        t.nm = nm; t.v = v; t.pc = pc; t.alu = alu; t.op = op; t.mreq = mreq;
        t.dok = dok; t.rd = rd; t.wsa = wsa; t.fl = fl; t.pend = pend;
        t.x_allow = xa; t.x_tows = xt; t.x_we = xw; t.x_busy = xb; t.x_pc = xpc; t.cw = cw; t.x_wd = xwd;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        logic ok;
        @(negedge clk);
        es_bus.es_to_ms_valid  = t.v;
        es_bus.es_pc           = t.pc;
        es_bus.es_res_from_mem = is_load(t.op);
        es_bus.es_rf_we        = ~(t.mreq & ~is_load(t.op));
        es_bus.es_rf_waddr     = 5'd9;
        es_bus.es_alu_result   = t.alu;
        es_bus.es_ld_op        = t.op;
        es_bus.es_mem_req      = t.mreq;
        es_bus.es_except       = exc_in;
        es_bus.es_req_pending  = t.pend;
        data_sram_data_ok      = t.dok;
        data_sram_rdata        = t.rd;
        ws_allowin             = t.wsa;
        ms_flush               = t.fl;
        #1;
        n_vec++;
        ok = (es_bus.ms_allowin === t.x_allow) && (ms_to_ws_valid === t.x_tows) && (ms_rf_we === t.x_we)
             && (ms_ld_busy === t.x_busy) && (ms_pc === t.x_pc) && (!t.cw || (ms_rf_wdata === t.x_wd));
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got allowin=%b to_ws=%b we=%b busy=%b pc=%h wdata=%h, want allowin=%b to_ws=%b we=%b busy=%b pc=%h wdata=%h(chk=%b)",
                     t.nm, es_bus.ms_allowin, ms_to_ws_valid, ms_rf_we, ms_ld_busy, ms_pc, ms_rf_wdata,
                     t.x_allow, t.x_tows, t.x_we, t.x_busy, t.x_pc, t.x_wd, t.cw);
        end else begin
            $display("vec %-14s allowin=%b to_ws=%b we=%b busy=%b pc=%h wdata=%h ok",
                     t.nm, es_bus.ms_allowin, ms_to_ws_valid, ms_rf_we, ms_ld_busy, ms_pc, ms_rf_wdata);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end else begin
            $display("chk %-14s value=%h ok", nm, act);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        exc_in = '0;
        resetn = 1'b0;
        es_bus.es_to_ms_valid = 1'b0; es_bus.es_pc = '0; es_bus.es_res_from_mem = 1'b0; es_bus.es_rf_we = 1'b0;
        es_bus.es_rf_waddr = '0; es_bus.es_alu_result = '0; es_bus.es_ld_op = '0; es_bus.es_mem_req = 1'b0;
        es_bus.es_except = '0; es_bus.es_req_pending = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1; ms_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        //       name            v  pc       alu          op    mq dok rdata         wsa fl pd  xa xt xw xb xpc     cw xwd
        tbl.push_back(mk("reset",        0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h0));
        tbl.push_back(mk("ldb_issue",    1, 32'h100, 32'h1003,    OPB,  1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h0));
        tbl.push_back(mk("ldb_resp",     0, 32'h0,   32'h0,       5'b0, 0, 1, 32'h80FF1234, 1, 0, 0, 1, 1, 1, 0, 32'h100, 1, 32'hFFFFFF80));
        tbl.push_back(mk("idle1",        0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h0));
        tbl.push_back(mk("ldhu_issue",   1, 32'h104, 32'h2002,    OPHU, 1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h0));
        tbl.push_back(mk("ldhu_wait1",   0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(mk("ldhu_wait2",   1, 32'h108, 32'h3000,    5'b0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(mk("ldhu_wait3",   1, 32'h108, 32'h3000,    5'b0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(mk("ldhu_resp",    1, 32'h108, 32'h3000,    5'b0, 0, 1, 32'h80FF1234, 1, 0, 0, 1, 1, 1, 0, 32'h104, 1, 32'h000080FF));
        tbl.push_back(mk("alu_pass",     0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 1, 0, 32'h108, 1, 32'h00003000));
        tbl.push_back(mk("alu2_issue",   1, 32'h10C, 32'h4444,    5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h108, 0, 32'h0));
        tbl.push_back(mk("alu2_stall",   0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 0, 32'h10C, 1, 32'h4444));
        tbl.push_back(mk("alu2_go",      0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 1, 0, 32'h10C, 1, 32'h4444));
        tbl.push_back(mk("ldw_issue",    1, 32'h110, 32'h6000,    OPW,  1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h10C, 0, 32'h0));
        tbl.push_back(mk("ldw_resp",     1, 32'h114, 32'h6000,    OPH,  1, 1, 32'h12348001, 1, 0, 0, 1, 1, 1, 0, 32'h110, 1, 32'h12348001));
        tbl.push_back(mk("ldh_resp",     1, 32'h118, 32'h6001,    OPBU, 1, 1, 32'h12348001, 1, 0, 0, 1, 1, 1, 0, 32'h114, 1, 32'hFFFF8001));
        tbl.push_back(mk("ldbu_resp",    0, 32'h0,   32'h0,       5'b0, 0, 1, 32'h12348001, 1, 0, 0, 1, 1, 1, 0, 32'h118, 1, 32'h00000080));
        tbl.push_back(mk("st_issue",     1, 32'h11C, 32'h7000,    5'b0, 1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h118, 0, 32'h0));
        tbl.push_back(mk("st_wait",      0, 32'h0,   32'h0,       5'b0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0, 32'h11C, 0, 32'h0));
        tbl.push_back(mk("st_resp",      0, 32'h0,   32'h0,       5'b0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 0, 0, 32'h11C, 1, 32'h7000));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            if (i == 0) begin
                check_val("rst_except", 32'(ms_except), 32'h0);
                check_val("rst_waddr", 32'(ms_rf_waddr), 32'h0);
`ifdef MS_PERF_CNT_EN
                check_val("rst_perf_wait", perf_wait_cyc, 32'h0);
                check_val("rst_perf_drop", 32'(perf_drop_cnt), 32'h0);
`endif
            end
        end

        // Response arrives while WB stalls: buffered value must survive bus changes, then clear
        apply(mk("rb_issue",      1, 32'h120, 32'h8000, OPW,  1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h11C, 0, 32'h0));
        apply(mk("rb_resp_stall", 0, 32'h0,   32'h0,    5'b0, 0, 1, 32'hAAAA5555, 0, 0, 0, 0, 1, 1, 0, 32'h120, 1, 32'hAAAA5555));
        apply(mk("rb_hold",       0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h11111111, 0, 0, 0, 0, 1, 1, 0, 32'h120, 1, 32'hAAAA5555));
        apply(mk("rb_release",    0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h22222222, 1, 0, 0, 1, 1, 1, 0, 32'h120, 1, 32'hAAAA5555));
        apply(mk("rb_issue2",     1, 32'h124, 32'h8004, OPW,  1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h120, 0, 32'h0));
        apply(mk("rb_cleared",    0, 32'h0,   32'h0,    5'b0, 0, 1, 32'h33333333, 1, 0, 0, 1, 1, 1, 0, 32'h124, 1, 32'h33333333));

        // Flush with MEM waiting and EX request pending: two responses dropped, third delivered
        apply(mk("fl_issue",      1, 32'h200, 32'h9000, OPW,  1, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h124, 0, 32'h0));
        apply(mk("fl_flush",      1, 32'h204, 32'h9004, OPW,  1, 0, 32'h0,        1, 1, 1, 0, 0, 1, 1, 32'h200, 0, 32'h0));
        apply(mk("fl_after",      0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h200, 0, 32'h0));
        apply(mk("fl_drop1",      1, 32'h208, 32'h900C, OPW,  1, 1, 32'hDEAD0001, 1, 0, 0, 1, 0, 0, 0, 32'h200, 0, 32'h0));
        apply(mk("fl_drop2",      0, 32'h0,   32'h0,    5'b0, 0, 1, 32'hDEAD0002, 1, 0, 0, 0, 0, 1, 1, 32'h208, 0, 32'h0));
        apply(mk("fl_deliver",    0, 32'h0,   32'h0,    5'b0, 0, 1, 32'hC0DE0003, 1, 0, 0, 1, 1, 1, 0, 32'h208, 1, 32'hC0DE0003));

        // Flush coinciding with capture, then flush killing a ready instruction in MEM
        apply(mk("flcap_in",      1, 32'h300, 32'hAAAA, 5'b0, 0, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0, 32'h208, 0, 32'h0));
        apply(mk("flcap_gone",    0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h300, 0, 32'h0));
        apply(mk("flmem_in",      1, 32'h304, 32'hBBBB, 5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h300, 0, 32'h0));
        apply(mk("flmem_kill",    0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h0,        1, 1, 0, 1, 0, 1, 0, 32'h304, 1, 32'hBBBB));
        apply(mk("flmem_gone",    0, 32'h0,   32'h0,    5'b0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h304, 0, 32'h0));

        // Excepting load without a memory request passes straight through
        exc_in = 7'(1 << EXC_SYS);
        apply(mk("exc_in",        1, 32'h400, 32'h5555, OPW,  0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h304, 0, 32'h0));
        exc_in = '0;
        apply(mk("exc_pass",      0, 32'h0,   32'h0,    5'b0, 0, 0, 32'hDEADBEEF, 1, 0, 0, 1, 1, 1, 0, 32'h400, 1, 32'hDEADBEEF));
        check_val("exc_vector", 32'(ms_except), 32'h00000004);
        check_val("exc_waddr", 32'(ms_rf_waddr), 32'h00000009);

`ifdef MS_PERF_CNT_EN
        check_val("perf_wait", perf_wait_cyc, 32'd15);
        check_val("perf_drop", 32'(perf_drop_cnt), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
